// File: rtl/mult_addr_gen_pkg.sv
// Shared types and constants for the LDM/STM address generator.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  localparam int WORD_BYTES = 4;

  // Addressing modes, encoded as {P,U}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/mult_addr_gen_if.sv
// Descriptor, register-index and memory-beat signals of mult_addr_gen.
// MULT_ADDR_GEN_CHECK_EN adds the err status line.
interface mult_addr_gen_if #(parameter int ADDR_W = 32);
  logic              start;
  logic [15:0]       reg_list;
  logic [ADDR_W-1:0] base;
  logic              pre;
  logic              up;
  logic              wb;
  logic              reg_valid;
  logic [3:0]        reg_idx;
  logic              reg_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_reg;
  logic              mem_last;
  logic              mem_ready;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_data;
  logic              busy;
  logic              done;
`ifdef MULT_ADDR_GEN_CHECK_EN
  logic              err;
`endif

  modport slave (
    input  start, reg_list, base, pre, up, wb, reg_valid, reg_idx, mem_ready,
`ifdef MULT_ADDR_GEN_CHECK_EN
    output err,
`endif
    output reg_ready, mem_valid, mem_addr, mem_reg, mem_last,
    output wb_valid, wb_data, busy, done
  );

  modport master (
    output start, reg_list, base, pre, up, wb, reg_valid, reg_idx, mem_ready,
`ifdef MULT_ADDR_GEN_CHECK_EN
    input  err,
`endif
    input  reg_ready, mem_valid, mem_addr, mem_reg, mem_last,
    input  wb_valid, wb_data, busy, done
  );
endinterface

// File: rtl/mult_addr_gen_pop_count16.sv
// 16-bit population count, purely combinational.
module pop_count16 (
  input  logic [15:0] i_vec,
  output logic [4:0]  o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 16; i++) o_cnt = o_cnt + 5'(i_vec[i]);
  end
endmodule

// File: rtl/mult_addr_gen.sv
// LDM/STM beat address generator: one word address per decoded register index.
// MULT_ADDR_GEN_CHECK_EN enables register-list consistency checking (err output).
module mult_addr_gen
  import mult_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NREG   = 16
) (
  input  logic           clk,
  input  logic           rst,
  mult_addr_gen_if.slave bus
);
  localparam int CNT_W = $clog2(NREG + 1);
  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  w_cnt, r_remain;
  logic [ADDR_W-1:0] w_span, w_start_addr, w_final;
  logic [ADDR_W-1:0] r_addr, r_final, r_mem_addr, r_wb_data;
  logic [3:0]        r_mem_reg;
  logic              r_w, r_mem_valid, r_mem_last;
  logic              w_cap, w_accept, w_beat_done, w_enter_wb;
  logic              w_reg_ready, w_busy, w_done, w_wb_valid;

  pop_count16 u_pop (.i_vec(bus.reg_list), .o_cnt(w_cnt));

  assign w_span = ADDR_W'(w_cnt) * WORD;

  always_comb begin
    w_start_addr = bus.base;
    case ({bus.pre, bus.up})
      MODE_IA: w_start_addr = bus.base;
      MODE_IB: w_start_addr = bus.base + WORD;
      MODE_DA: w_start_addr = bus.base - w_span + WORD;
      MODE_DB: w_start_addr = bus.base - w_span;
      default: w_start_addr = bus.base;
    endcase
  end

  assign w_final     = bus.up ? bus.base + w_span : bus.base - w_span;
  assign w_cap       = (r_state == IDLE) && bus.start;
  assign w_accept    = bus.reg_valid && w_reg_ready;
  assign w_beat_done = r_mem_valid && bus.mem_ready;
  assign w_enter_wb  = (w_next == WB) && (r_state != WB);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = (w_cnt == '0) ? WB : XFER;
      XFER: if (w_beat_done && r_mem_last) w_next = WB;
      WB:   w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != IDLE);
    w_done      = (r_state == DONE);
    w_wb_valid  = (r_state == WB) && r_w;
    w_reg_ready = (r_state == XFER) && (r_remain != '0) &&
                  (!r_mem_valid || bus.mem_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_remain    <= '0;
      r_addr      <= '0;
      r_final     <= '0;
      r_w         <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_reg   <= '0;
      r_mem_last  <= 1'b0;
      r_wb_data   <= '0;
    end else begin
      if (w_cap) begin
        r_remain <= w_cnt;
        r_addr   <= {w_start_addr[ADDR_W-1:2], 2'b00};
        r_final  <= w_final;
        r_w      <= bus.wb;
      end
      // A new beat may replace the current one in the same cycle it is taken
      if (w_accept) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= r_addr;
        r_mem_reg   <= bus.reg_idx;
        r_mem_last  <= (r_remain == CNT_W'(1));
        r_addr      <= r_addr + WORD;
        r_remain    <= r_remain - CNT_W'(1);
      end else if (bus.mem_ready) begin
        r_mem_valid <= 1'b0;
        r_mem_last  <= 1'b0;
      end
      if (w_enter_wb) r_wb_data <= (r_state == IDLE) ? bus.base : r_final;
    end
  end

`ifdef MULT_ADDR_GEN_CHECK_EN
  logic [15:0] r_list_rem;
  logic [3:0]  r_prev;
  logic        r_have_prev, r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_list_rem  <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_cap) begin
      r_list_rem  <= bus.reg_list;
      r_have_prev <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      if (!r_list_rem[bus.reg_idx] || (r_have_prev && (bus.reg_idx <= r_prev)))
        r_err <= 1'b1;
      r_list_rem[bus.reg_idx] <= 1'b0;
      r_prev      <= bus.reg_idx;
      r_have_prev <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.reg_ready = w_reg_ready;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_reg   = r_mem_reg;
  assign bus.mem_last  = r_mem_last;
  assign bus.wb_valid  = w_wb_valid;
  assign bus.wb_data   = r_wb_data;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule

// File: tb/tb_mult_addr_gen.sv
// Directed bench for mult_addr_gen: each addressing mode, backpressure, empty list, wrap, reset abort.
module tb_mult_addr_gen;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mult_addr_gen_if #(.ADDR_W(32)) bus ();

  mult_addr_gen #(.ADDR_W(32), .NREG(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_valid"}, bus.mem_valid, 0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_reg"},   bus.mem_reg,   0);
    chk({tag, "_mem_last"},  bus.mem_last,  0);
    chk({tag, "_wb_valid"},  bus.wb_valid,  0);
    chk({tag, "_wb_data"},   bus.wb_data,   0);
    chk({tag, "_busy"},      bus.busy,      0);
    chk({tag, "_done"},      bus.done,      0);
    chk({tag, "_reg_ready"}, bus.reg_ready, 0);
  endtask

  // Returns at the negedge after the start edge
  task automatic start_op(input logic [31:0] b, input logic [15:0] list,
                          input logic p, input logic u, input logic w);
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.reg_list = list;
    bus.pre = p; bus.up = u; bus.wb = w; bus.reg_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic xfer(input string nm, input logic [31:0] b, input logic [15:0] list,
                      input logic p, input logic u, input logic w,
                      input logic [31:0] exp_first, input logic [31:0] exp_wb, input int stall);
    logic [3:0] idx [16];
    int n = 0, k = 0, off = 0, cyc = 0, st = stall;
    for (int i = 0; i < 16; i++) if (list[i]) begin idx[n] = 4'(i); n++; end
    bus.mem_ready = 1'b1;
    start_op(b, list, p, u, w);
    while (k < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = !(st > 0 && bus.mem_valid);
      if (bus.mem_valid) begin
        chk({nm, "_addr"}, bus.mem_addr, exp_first + 32'(4 * k));
        chk({nm, "_reg"},  bus.mem_reg,  32'(idx[k]));
        chk({nm, "_last"}, bus.mem_last, 32'(k == n - 1));
        if (bus.mem_ready) k++;
        else begin
          st--;
          #1 chk({nm, "_stall_reg_ready"}, bus.reg_ready, 0);
        end
      end
      bus.reg_valid = (off < n);
      if (off < n) bus.reg_idx = idx[off];
      #1;
      if (bus.reg_valid && bus.reg_ready) off++;
    end
    chk({nm, "_beats"}, k, n);
    bus.reg_valid = 1'b0;
    bus.mem_ready = 1'b1;
    if (n > 0) @(negedge clk);
    chk({nm, "_wb_valid"}, bus.wb_valid, 32'(w));
    chk({nm, "_wb_data"},  bus.wb_data,  exp_wb);
    chk({nm, "_wb_busy"},  bus.busy,     1);
    chk({nm, "_wb_mem_valid"}, bus.mem_valid, 0);
    @(negedge clk);
    chk({nm, "_done"},     bus.done,     1);
    chk({nm, "_done_wbv"}, bus.wb_valid, 0);
    @(negedge clk);
    chk({nm, "_idle_done"}, bus.done, 0);
    chk({nm, "_idle_busy"}, bus.busy, 0);
`ifdef MULT_ADDR_GEN_CHECK_EN
    chk({nm, "_err"}, bus.err, 0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.reg_list = '0; bus.base = '0;
    bus.pre = 1'b0; bus.up = 1'b0; bus.wb = 1'b0;
    bus.reg_valid = 1'b0; bus.reg_idx = '0; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b1;

    xfer("ia",    32'h0000_1000, 16'h0054, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_100C, 0);
    xfer("db",    32'h0000_2000, 16'h8001, 1'b1, 1'b0, 1'b1, 32'h0000_1FF8, 32'h0000_1FF8, 0);
    xfer("ib",    32'h0000_0100, 16'h0003, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0108, 0);
    xfer("da",    32'h0000_0100, 16'h0003, 1'b0, 1'b0, 1'b0, 32'h0000_00FC, 32'h0000_00F8, 0);
    xfer("stall", 32'h0000_3000, 16'h000E, 1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h0000_300C, 3);
    xfer("empty", 32'h7777_0000, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h7777_0000, 0);
    xfer("wrap",  32'hFFFF_FFFC, 16'h0003, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 0);

    // Abort with a beat stalled in flight
    start_op(32'h0000_4000, 16'h0054, 1'b0, 1'b1, 1'b1);
    bus.reg_valid = 1'b1; bus.reg_idx = 4'd2; bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("abort_pending", bus.mem_valid, 1);
    bus.reg_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("abort");
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    xfer("post_rst", 32'h0000_4000, 16'h0054, 1'b0, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_400C, 0);

`ifdef MULT_ADDR_GEN_CHECK_EN
    start_op(32'h0000_5000, 16'h0054, 1'b0, 1'b1, 1'b1);
    bus.reg_valid = 1'b1; bus.reg_idx = 4'd3; bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("err_beat", bus.mem_reg, 3);
    chk("err_set",  bus.err,     1);
    bus.reg_valid = 1'b0;
    @(negedge clk);
    chk("err_hold", bus.err, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("err_rst", bus.err, 0);
    rst = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
